// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin, burst-limited arbiter of two AXI-Stream requesters into a FIFO.
// Optional per-requester beat statistics enabled by macro FIFO_ARBITER_STATS_EN. Rev 1.0
`default_nettype none

module fifo_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16384,
  parameter int CNTW  = 14,
  parameter int BURST = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [WIDTH-1:0] in0_V_V_TDATA,
  input  logic             in0_V_V_TVALID,
  output logic             in0_V_V_TREADY,
  input  logic [WIDTH-1:0] in1_V_V_TDATA,
  input  logic             in1_V_V_TVALID,
  output logic             in1_V_V_TREADY,
  output logic [WIDTH-1:0] out_V_V_TDATA,
  output logic             out_V_V_TVALID,
  input  logic             out_V_V_TREADY,
  input  logic [CNTW-1:0]  fifo_count,
  output logic [1:0]       grant
`ifdef FIFO_ARBITER_STATS_EN
  ,
  output logic [31:0]      stat0_beats,
  output logic [31:0]      stat1_beats
`endif
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [31:0] LIMIT = 32'(DEPTH - BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] beat_cnt;
  logic          last_served;   // 1: in1 was served last, so in0 has priority
  logic [31:0]   count_ext;
  logic          room;
  logic          xfer;

  assign count_ext = 32'(fifo_count);
  assign room      = (count_ext <= LIMIT);
  assign xfer      = out_V_V_TVALID & out_V_V_TREADY;

  always_comb begin
    state_next     = state;
    grant          = 2'b00;
    out_V_V_TDATA  = '0;
    out_V_V_TVALID = 1'b0;
    in0_V_V_TREADY = 1'b0;
    in1_V_V_TREADY = 1'b0;
    case (state)
      IDLE: begin
        if (room) begin
          if (last_served) begin
            if (in0_V_V_TVALID)      state_next = GNT0;
            else if (in1_V_V_TVALID) state_next = GNT1;
          end else begin
            if (in1_V_V_TVALID)      state_next = GNT1;
            else if (in0_V_V_TVALID) state_next = GNT0;
          end
        end
      end
      GNT0: begin
        grant          = 2'b01;
        out_V_V_TDATA  = in0_V_V_TDATA;
        out_V_V_TVALID = in0_V_V_TVALID;
        in0_V_V_TREADY = out_V_V_TREADY;
        if (!in0_V_V_TVALID || (out_V_V_TREADY && beat_cnt == LAST_BEAT))
          state_next = IDLE;
      end
      GNT1: begin
        grant          = 2'b10;
        out_V_V_TDATA  = in1_V_V_TDATA;
        out_V_V_TVALID = in1_V_V_TVALID;
        in1_V_V_TREADY = out_V_V_TREADY;
        if (!in1_V_V_TVALID || (out_V_V_TREADY && beat_cnt == LAST_BEAT))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      last_served <= 1'b1;
    end else begin
      state <= state_next;
      // IDLE always precedes a grant, so clearing here covers grant entry
      if (state == IDLE)
        beat_cnt <= '0;
      else if (xfer)
        beat_cnt <= beat_cnt + BW'(1);
      if (state == IDLE && state_next == GNT0)
        last_served <= 1'b0;
      else if (state == IDLE && state_next == GNT1)
        last_served <= 1'b1;
    end
  end

`ifdef FIFO_ARBITER_STATS_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat0_beats <= '0;
      stat1_beats <= '0;
    end else begin
      if (state == GNT0 && xfer) stat0_beats <= stat0_beats + 32'd1;
      if (state == GNT1 && xfer) stat1_beats <= stat1_beats + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench for fifo_arbiter: cycle vector table, scoreboard of beats, reset/back-pressure/burst sequences.
`default_nettype none

module tb_fifo_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in0_data, in1_data, out_data;
  logic        in0_valid, in1_valid, out_ready;
  logic        in0_ready, in1_ready, out_valid;
  logic [13:0] fifo_count;
  logic [1:0]  grant;
`ifdef FIFO_ARBITER_STATS_EN
  logic [31:0] stat0, stat1;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  fifo_arbiter dut (
    .ap_clk         (clk),
    .ap_rst         (rst),
    .in0_V_V_TDATA  (in0_data),
    .in0_V_V_TVALID (in0_valid),
    .in0_V_V_TREADY (in0_ready),
    .in1_V_V_TDATA  (in1_data),
    .in1_V_V_TVALID (in1_valid),
    .in1_V_V_TREADY (in1_ready),
    .out_V_V_TDATA  (out_data),
    .out_V_V_TVALID (out_valid),
    .out_V_V_TREADY (out_ready),
    .fifo_count     (fifo_count),
    .grant          (grant)
`ifdef FIFO_ARBITER_STATS_EN
    ,
    .stat0_beats    (stat0),
    .stat1_beats    (stat1)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: every accepted beat on the output must match the next queued beat
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got beat %0h expected none at %0t", out_data, $time);
      end else begin
        check("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    logic x0, x1;
    x0 = in0_valid && in0_ready;
    x1 = in1_valid && in1_ready;
    @(posedge clk);
    #1;
    if (x0) in0_data = in0_data + 8'd1;
    if (x1) in1_data = in1_data + 8'd1;
  endtask

  typedef struct {
    logic        v0, v1, ordy;
    logic [13:0] cnt;
    logic [1:0]  g;
    logic        r0, r1, ov;
  } vec_t;

  function automatic vec_t mk(logic v0, logic v1, logic ordy, logic [13:0] cnt,
                              logic [1:0] g, logic r0, logic r1, logic ov);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.ordy = ordy; v.cnt = cnt;
    v.g = g; v.r0 = r0; v.r1 = r1; v.ov = ov;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    logic [7:0] d0, b0, b1;
    logic [7:0] exp_d;
    logic [1:0] eg;

    rst = 1'b1;
    in0_data = 8'h00; in1_data = 8'h80;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0; fifo_count = '0;
    #2;
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_ready", {30'd0, in0_ready, in1_ready}, 32'd0);
    check("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check("rst_odata", {24'd0, out_data}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    tbl[0]  = mk(1, 0, 1, 14'd16369, 2'b00, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 14'd16369, 2'b00, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 14'd16368, 2'b00, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 14'd16368, 2'b01, 1, 0, 1);
    tbl[4]  = mk(0, 0, 1, 14'd0,     2'b01, 1, 0, 0);
    tbl[5]  = mk(0, 1, 1, 14'd0,     2'b00, 0, 0, 0);
    for (int i = 6; i < 11; i++) tbl[i] = mk(0, 1, 1, 14'd0, 2'b10, 0, 1, 1);
    tbl[11] = mk(0, 0, 1, 14'd0,     2'b10, 0, 1, 0);
    tbl[12] = mk(0, 0, 1, 14'd0,     2'b00, 0, 0, 0);
    tbl[13] = mk(1, 1, 1, 14'd0,     2'b00, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 14'd0,     2'b01, 0, 0, 1);
    tbl[15] = mk(0, 1, 0, 14'd0,     2'b01, 0, 0, 0);
    tbl[16] = mk(1, 1, 1, 14'd0,     2'b00, 0, 0, 0);
    tbl[17] = mk(1, 1, 1, 14'd0,     2'b10, 0, 1, 1);
    tbl[18] = mk(1, 0, 1, 14'd0,     2'b10, 0, 1, 0);
    tbl[19] = mk(1, 0, 1, 14'd16369, 2'b00, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      in0_valid = tbl[i].v0; in1_valid = tbl[i].v1;
      out_ready = tbl[i].ordy; fifo_count = tbl[i].cnt;
      exp_d = (tbl[i].g == 2'b01) ? in0_data : (tbl[i].g == 2'b10) ? in1_data : 8'h00;
      if (tbl[i].ov && tbl[i].ordy) sb.push_back(exp_d);
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), {30'd0, grant}, {30'd0, tbl[i].g});
      check($sformatf("vec%0d_ready", i), {30'd0, in0_ready, in1_ready}, {30'd0, tbl[i].r0, tbl[i].r1});
      check($sformatf("vec%0d_ovalid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      check($sformatf("vec%0d_odata", i), {24'd0, out_data}, {24'd0, exp_d});
      tick();
    end
`ifdef FIFO_ARBITER_STATS_EN
    check("stat0_beats", stat0, 32'd1);
    check("stat1_beats", stat1, 32'd6);
`endif

    // in1 alone for 7 beats, then reset lands mid-burst between clock edges
    in0_valid = 1'b0; in1_valid = 1'b1; out_ready = 1'b1; fifo_count = '0;
    @(negedge clk);
    check("pre_g1_idle", {30'd0, grant}, 32'd0);
    tick();
    for (int i = 0; i < 7; i++) begin
      sb.push_back(in1_data);
      @(negedge clk);
      check("g1_grant", {30'd0, grant}, 32'd2);
      tick();
    end
    check("g1_beat8_grant", {30'd0, grant}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_grant", {30'd0, grant}, 32'd0);
    check("midrst_ready", {30'd0, in0_ready, in1_ready}, 32'd0);
    check("midrst_ovalid", {31'd0, out_valid}, 32'd0);
    check("midrst_odata", {24'd0, out_data}, 32'd0);

    // After release both request; in0 must win, then be held under back-pressure
    in0_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {30'd0, grant}, 32'd0);
    tick();
    d0 = in0_data;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("bp_grant", {30'd0, grant}, 32'd1);
      check("bp_ovalid", {31'd0, out_valid}, 32'd1);
      check("bp_odata", {24'd0, out_data}, {24'd0, d0});
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) sb.push_back(d0 + 8'(j));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("bp_burst_grant", {30'd0, grant}, 32'd1);
      tick();
    end
    @(negedge clk);
    check("bp_end_idle", {30'd0, grant}, 32'd0);
    check("bp_sb_drained", sb.size(), 32'd0);

    // Saturated alternation from a fresh reset: 16 beats each, one IDLE between
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1; fifo_count = '0;
    b0 = in0_data; b1 = in1_data;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 16; j++)
        sb.push_back(((b % 2) == 0) ? b0 + 8'((b / 2) * 16 + j) : b1 + 8'((b / 2) * 16 + j));
    for (int k = 0; k < 69; k++) begin
      eg = ((k % 17) == 0) ? 2'b00 : (((k / 17) % 2) == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      check($sformatf("rr_grant_k%0d", k), {30'd0, grant}, {30'd0, eg});
      tick();
    end
    check("rr_sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
